// File: rtl/reg_file_scoreboard.sv
// rtl/reg_file_scoreboard.sv - register file with per-register pending-write scoreboard (optional RF_BYPASS_EN write-through forwarding)
module reg_file_scoreboard #(
  parameter int WIDTH       = 16,
  parameter int ADDR_WIDTH  = 2,
  parameter int HARDWIRE_R0 = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  input  logic [ADDR_WIDTH-1:0] rd_addr2,
  output logic [WIDTH-1:0]      rd_data1,
  output logic [WIDTH-1:0]      rd_data2,
  output logic                  rd_busy1,
  output logic                  rd_busy2,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  issue_en,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  input  logic                  flush,
  output logic                  pending_any
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;
  logic             wr_ok;
  logic             issue_ok;

  // Accesses to a hardwired r0 are dropped here so r0 storage and pending bit never change
  assign wr_ok    = wr_en    && !((HARDWIRE_R0 != 0) && (wr_addr    == '0));
  assign issue_ok = issue_en && !((HARDWIRE_R0 != 0) && (issue_addr == '0));

  // Scoreboard next state: writeback clears, issue sets afterwards so a colliding issue wins; flush overrides all
  always_comb begin
    pending_d = pending_q;
    if (wr_ok) begin
      pending_d[wr_addr] = 1'b0;
    end
    if (flush) begin
      pending_d = '0;
    end else if (issue_ok) begin
      pending_d[issue_addr] = 1'b1;
    end
  end

  // Pending vector register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Data array; flush does not block a writeback
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_ok) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Read port 1: array lookup, optional same-cycle forwarding of the writeback, r0 override
  always_comb begin
    rd_data1 = regs_q[rd_addr1];
    rd_busy1 = pending_q[rd_addr1];
`ifdef RF_BYPASS_EN
    // Forwarded data is valid for this reader even if a same-cycle issue re-arms the pending bit
    if (wr_ok && (wr_addr == rd_addr1)) begin
      rd_data1 = wr_data;
      rd_busy1 = 1'b0;
    end
`endif
    if ((HARDWIRE_R0 != 0) && (rd_addr1 == '0)) begin
      rd_data1 = '0;
      rd_busy1 = 1'b0;
    end
  end

  // Read port 2: same structure as port 1
  always_comb begin
    rd_data2 = regs_q[rd_addr2];
    rd_busy2 = pending_q[rd_addr2];
`ifdef RF_BYPASS_EN
    if (wr_ok && (wr_addr == rd_addr2)) begin
      rd_data2 = wr_data;
      rd_busy2 = 1'b0;
    end
`endif
    if ((HARDWIRE_R0 != 0) && (rd_addr2 == '0)) begin
      rd_data2 = '0;
      rd_busy2 = 1'b0;
    end
  end

  // Any producer in flight
  assign pending_any = |pending_q;

endmodule

// File: doc/reg_file_scoreboard.md
# reg_file_scoreboard

Parametrised register file with two combinational read ports, one synchronous write port and a per-register pending-write scoreboard. It sits in the decode stage of the pipelined CPU. It supplies operands to the datapath and raises per-operand busy flags so the hazard unit can stall until an in-flight producer writes back. It replaces the single-cycle, fixed 4×16 register file used by earlier cores.

## Interface
Parameters:
- WIDTH, 16: register data width in bits.
- ADDR_WIDTH, 2: register address width; depth = 2**ADDR_WIDTH.
- HARDWIRE_R0, 0: when 1, register 0 always reads 0, and writes and issues to it are ignored.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- rd_addr1  input  ADDR_WIDTH  read port 1 address.
- rd_addr2  input  ADDR_WIDTH  read port 2 address.
- rd_data1  output  WIDTH  read port 1 data.
- rd_data2  output  WIDTH  read port 2 data.
- rd_busy1  output  1  pending write outstanding on rd_addr1.
- rd_busy2  output  1  pending write outstanding on rd_addr2.
- wr_en  input  1  writeback strobe.
- wr_addr  input  ADDR_WIDTH  writeback destination.
- wr_data  input  WIDTH  writeback data.
- issue_en  input  1  an instruction with a destination register issues this cycle.
- issue_addr  input  ADDR_WIDTH  destination of the issuing instruction.
- flush  input  1  pipeline flush; clears all pending bits.
- pending_any  output  1  OR of all pending bits.

## Operation
- Storage: DEPTH×WIDTH data array and a DEPTH-bit pending vector.
- Write: on a clk edge with wr_en=1, regs[wr_addr] <= wr_data and pending[wr_addr] <= 0.
- Issue: on a clk edge with issue_en=1, pending[issue_addr] <= 1.
- Issue and write to the same address on the same edge: the issue wins. The data is written and pending stays 1, because a newer producer is now in flight.
- Issue and write to different addresses on the same edge: both take effect independently.
- Flush: on a clk edge with flush=1, every pending bit is cleared and any issue_en that cycle is ignored. A wr_en in the same cycle still writes data.
- Reads: rd_dataN = regs[rd_addrN], combinational. rd_busyN = pending[rd_addrN], combinational.
- HARDWIRE_R0=1: for address 0, reads return 0 and busy returns 0. Writes and issues to address 0 are dropped, so pending[0] stays 0.
- Every address in range 0..DEPTH-1 is valid. No out-of-range case exists.
- pending_any = |pending, combinational.

## Timing
- Reset (reset_n=0, asynchronous): all regs = 0 and all pending = 0. Consequently rd_data1/2 = 0, rd_busy1/2 = 0 and pending_any = 0 while reset is held.
- Reset deassertion is sampled at the next rising edge. No operation is lost other than the ones in progress during reset.
- Read latency is 0 cycles (combinational). Write-to-storage latency is 1 edge.
- A write-back and a pending-bit clear on edge N are visible from edge N onwards. Same-cycle visibility depends on the configuration macro.
- An issue on edge N makes rd_busy assert for the issued address after edge N.

## Configuration
- Macro: RF_BYPASS_EN.
- Defined: write-through forwarding. If wr_en=1 and wr_addr==rd_addrN (and not address 0 when HARDWIRE_R0=1), then rd_dataN = wr_data in the same cycle and rd_busyN = 0, unless pending for that address is being re-set by a same-cycle issue. In that case rd_busyN = 0 still, because the current data is valid for the current reader.
- Undefined: no forwarding. rd_dataN returns the pre-edge register value, and rd_busyN reflects the pre-edge pending bit during the write cycle.

## Test plan
- Reset: hold reset_n=0 mid-run after writing r1=16'h1234 -> rd_data=0 for all addresses and pending_any=0 immediately, with no clock edge needed.
- Write/read: write r2=16'hBEEF, then next cycle set rd_addr1=2 -> rd_data1=16'hBEEF. With RF_BYPASS_EN defined, rd_data1=16'hBEEF in the write cycle; without it, the old value (0) is read in the write cycle.
- Scoreboard: issue r3 -> rd_busy2=1 for rd_addr2=3 on the next cycle. Write r3=16'h0042 -> busy clears (same cycle with bypass, next cycle without) and rd_data2=16'h0042.
- Collision: issue r1 and write r1=16'h5555 on the same edge -> r1 data is 16'h5555 and pending[1] stays 1, so rd_busy=1 afterwards.
- Flush: issue r0, r1 and r2 on successive cycles, then assert flush together with issue r3 -> all rd_busy=0 and pending_any=0 after the edge.
- HARDWIRE_R0=1: write r0=16'hFFFF and issue r0 -> rd_data for address 0 = 0, busy=0 and pending_any=0.
